// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the two-master arbiter.
// Holds the bus widths, the arbiter state encoding and the request payload
// struct that gets muxed onto the slave port.
package wb_pkg;

  localparam int unsigned ADR_W   = 16;
  localparam int unsigned DAT_W   = 32;
  localparam int unsigned SEL_W   = 4;
  localparam int unsigned STALL_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  // Master request as seen by the slave; field order matches the s_* ports.
  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
    logic             we;
    logic [SEL_W-1:0] sel;
    logic             stb;
    logic             cyc;
  } wb_req_t;

endpackage

// File: rtl/wb_stall_timer.sv
// Bus-stall watchdog for the arbiter.
// Counts cycles in which the granted master strobes without a slave ack and
// raises a one-cycle registered err pulse towards that master on timeout.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   busy      - arbiter is in a grant state
//   gnt_idx   - index of the granted master
//   stall     - granted, strobing and not acked this cycle
//   ack       - slave ack this cycle
//   err       - per-master registered timeout pulse
module wb_stall_timer
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       busy,
  input  logic       gnt_idx,
  input  logic       stall,
  input  logic       ack,
  output logic [1:0] err
);

  localparam logic [STALL_W-1:0] TERM = STALL_W'(TIMEOUT_CYCLES - 1);

  logic [STALL_W-1:0] cnt;

  // Counter clears while idle, on ack, and when it fires; ack always beats timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      err <= '0;
    end else begin
      err <= '0;
      if (!busy || ack) begin
        cnt <= '0;
      end else if (stall) begin
        if (cnt == TERM) begin
          cnt          <= '0;
          err[gnt_idx] <= 1'b1;
        end else begin
          cnt <= cnt + STALL_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/wb_arb2.sv
// Two-master round-robin Wishbone arbiter sharing one slave.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   m0_* / m1_* inputs    - master requests (adr, dat, we, sel, stb, cyc)
//   m0_* / m1_* outputs   - ack, timeout err and read data back to masters
//   s_* outputs           - request of the granted master (zero when idle)
//   s_ack_i, s_dat_i      - slave response
module wb_arb2
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  input  logic             m0_we_i,
  input  logic [SEL_W-1:0] m0_sel_i,
  input  logic             m0_stb_i,
  input  logic             m0_cyc_i,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  output logic [DAT_W-1:0] m0_dat_o,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  input  logic             m1_we_i,
  input  logic [SEL_W-1:0] m1_sel_i,
  input  logic             m1_stb_i,
  input  logic             m1_cyc_i,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic [DAT_W-1:0] m1_dat_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [DAT_W-1:0] s_dat_o,
  output logic             s_we_o,
  output logic [SEL_W-1:0] s_sel_o,
  output logic             s_stb_o,
  output logic             s_cyc_o,
  input  logic             s_ack_i,
  input  logic [DAT_W-1:0] s_dat_i
);

  arb_state_t state, state_nxt;
  logic       last_gnt, last_gnt_nxt;
  wb_req_t    m0_req, m1_req, s_req;
  logic [1:0] err_q;
  logic       busy, stall;

  // State register; last_gnt resets to 1 so m0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  // Arbitration only from IDLE; a grant is held until the owner drops cyc.
  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_nxt    = last_gnt ? GNT0 : GNT1;
          last_gnt_nxt = ~last_gnt;
        end else if (m0_cyc_i) begin
          state_nxt    = GNT0;
          last_gnt_nxt = 1'b0;
        end else if (m1_cyc_i) begin
          state_nxt    = GNT1;
          last_gnt_nxt = 1'b1;
        end
      end
      GNT0:    if (!m0_cyc_i) state_nxt = IDLE;
      GNT1:    if (!m1_cyc_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign m0_req = {m0_adr_i, m0_dat_i, m0_we_i, m0_sel_i, m0_stb_i, m0_cyc_i};
  assign m1_req = {m1_adr_i, m1_dat_i, m1_we_i, m1_sel_i, m1_stb_i, m1_cyc_i};

  // Slave port follows the owner combinationally and is all-zero when idle.
  always_comb begin
    s_req = '0;
    if (state == GNT0)      s_req = m0_req;
    else if (state == GNT1) s_req = m1_req;
  end

  assign s_adr_o = s_req.adr;
  assign s_dat_o = s_req.dat;
  assign s_we_o  = s_req.we;
  assign s_sel_o = s_req.sel;
  assign s_stb_o = s_req.stb;
  assign s_cyc_o = s_req.cyc;

  assign m0_ack_o = s_ack_i && (state == GNT0);
  assign m1_ack_o = s_ack_i && (state == GNT1);
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign busy  = (state != IDLE);
  assign stall = busy && s_stb_o && !s_ack_i;

  wb_stall_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_stall_timer (
    .clk    (clk),
    .rst    (rst),
    .busy   (busy),
    .gnt_idx(state == GNT1),
    .stall  (stall),
    .ack    (s_ack_i),
    .err    (err_q)
  );

  // A late slave ack landing on the err cycle masks err so the two never coincide.
  assign m0_err_o = err_q[0] && !m0_ack_o;
  assign m1_err_o = err_q[1] && !m1_ack_o;

endmodule

// File: doc/wb_arb2.md
WB_ARB2 -- requirements
Module: wb_arb2

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1023: bus-stall cycles allowed before an error is returned; legal range 1 to 65535.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset. clk input 1: the single clock; every register updates on its rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 m0_adr_i, m1_adr_i  input  16  master address.
REQ-005 m0_dat_i, m1_dat_i  input  32  master write data.
REQ-006 m0_we_i, m1_we_i  input  1  master write enable.
REQ-007 m0_sel_i, m1_sel_i  input  4  master byte select.
REQ-008 m0_stb_i, m1_stb_i, m0_cyc_i, m1_cyc_i  input  1 each  master strobe and cycle.
REQ-009 m0_ack_o, m1_ack_o  output  1 each  acknowledge to master.
REQ-010 m0_err_o, m1_err_o  output  1 each  timeout error to master.
REQ-011 m0_dat_o, m1_dat_o  output  32  read data to master.
REQ-012 s_adr_o 16, s_dat_o 32, s_we_o 1, s_sel_o 4, s_stb_o 1, s_cyc_o 1  output  muxed slave request.
REQ-013 s_ack_i 1, s_dat_i 32  input  slave response; typical slave is the UART peripheral.

Function
REQ-014 wb_arb2 SHALL share one Wishbone slave between masters m0 and m1 using an FSM with states IDLE, GNT0 and GNT1.
REQ-015 A master requests when its cyc_i is high.
REQ-016 In IDLE, the next state SHALL be GNT0 when only m0 requests and GNT1 when only m1 requests.
REQ-017 When both master request in IDLE, the grant SHALL go to the master not recorded in last_gnt (round-robin).
REQ-018 last_gnt SHALL update to the granted index on every IDLE->GNTx transition.
REQ-019 Arbitration SHALL take exactly one cycle: request sampled in IDLE, slave signals driven from the next cycle.
REQ-020 In GNTx, all s_* outputs SHALL combinationally follow master x's signals.
REQ-021 In IDLE, s_stb_o and s_cyc_o SHALL be 0, and s_adr_o, s_dat_o, s_we_o and s_sel_o SHALL be 0.
REQ-022 mx_ack_o SHALL equal s_ack_i AND (state==GNTx); the non-granted master SHALL never see ack.
REQ-023 m0_dat_o and m1_dat_o SHALL both equal s_dat_i at all times.
REQ-024 A granted master SHALL keep the grant until its cyc_i is low at a clock edge; the FSM then returns to IDLE, independent of the other master's requests.
REQ-025 Re-arbitration SHALL happen only from IDLE, with no back-to-back GNTx->GNTy transition; the minimum gap between grants is one IDLE cycle.
REQ-026 A 16-bit stall counter SHALL increment each cycle in GNTx with s_stb_o=1 and s_ack_i=0.
REQ-027 The stall counter SHALL clear on s_ack_i, on entering IDLE, and on timeout.
REQ-028 When the stall counter equals TIMEOUT_CYCLES-1 and s_ack_i=0, mx_err_o SHALL assert for exactly one cycle (registered, next cycle) and the counter SHALL clear.
REQ-029 On timeout the grant SHALL be retained, and the master SHALL drop cyc_i to release it.
REQ-030 When s_ack_i and the timeout condition occur in the same cycle, ack SHALL win and no err SHALL be raised.
REQ-031 When cyc_i drops in the same cycle as s_ack_i, ack SHALL be delivered and the FSM SHALL go to IDLE.
REQ-032 mx_err_o SHALL never be asserted together with mx_ack_o.

Reset
REQ-033 On rst, state SHALL be IDLE, last_gnt SHALL be 1 (so m0 wins the first contention), the stall counter SHALL be 0, and m0_err_o and m1_err_o SHALL be 0.
REQ-034 Reset asserted mid-transaction SHALL force s_stb_o=s_cyc_o=0 and both ack outputs to 0 from the cycle after the reset edge, and no err pulse SHALL be generated.

Structure
REQ-035 The state encoding (IDLE=0, GNT0=1, GNT1=2) and the Wishbone widths (ADR=16, DAT=32, SEL=4) SHALL live in the shared package wb_pkg.
REQ-036 wb_arb2 SHALL have one sub-module, wb_stall_timer (counter plus compare plus err pulse), instantiated once.

Verification
REQ-037 Single master: m0 writes 0x41 to adr 0x0000, slave acks 3 cycles after s_stb_o -> s_* mirror m0 one cycle after cyc; m0_ack_o pulses once; m1_ack_o stays 0.
REQ-038 Contention after reset: m0 and m1 raise cyc in the same cycle -> GNT0 first; after m0 drops cyc, one IDLE cycle, then GNT1.
REQ-039 Round-robin: three consecutive simultaneous contentions -> grant order m0, m1, m0.
REQ-040 Timeout: TIMEOUT_CYCLES=8, slave never acks -> m0_err_o pulses once, 8 cycles after s_stb_o rises; grant held until cyc drops.
REQ-041 Ack/timeout collision: s_ack_i arrives on the terminal stall cycle -> ack delivered and err stays 0.
REQ-042 Reset mid-read: rst asserted while in GNT1 with stb high -> next cycle s_cyc_o=0, state IDLE; a later single m1 request is granted normally.
